alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered results (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 64, ALU result width.
REQ-003 SHALL have parameter RA_W, default 5, register-address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  ALU result presented.
REQ-008 in_ready  output  1  buffer can accept.
REQ-009 in_data  input  WIDTH  ALU result value.
REQ-010 in_cout  input  1  ALU carry-out.
REQ-011 in_rd  input  RA_W  destination register.
REQ-012 out_valid  output  1  head entry available to writeback.
REQ-013 out_ready  input  1  writeback accepts head.
REQ-014 out_data / out_cout / out_rd  output  WIDTH / 1 / RA_W  head entry fields.
REQ-015 fwd_rs  input  RA_W  source register queried by operand fetch.
REQ-016 fwd_hit / fwd_data  output  1 / WIDTH  forwarding match and value.
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 Push SHALL occur when in_valid && in_ready && in_rd != 31; in_rd == 31 (XZR) SHALL be accepted (handshake completes) but not stored.
REQ-019 in_ready SHALL equal (count < DEPTH); combinational, no dependence on out_ready (no full-bypass).
REQ-020 Pop SHALL occur when out_valid && out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_data, out_cout, out_rd SHALL be 0 when empty.
REQ-022 Entry pushed at edge N SHALL be visible at out_* after edge N (one-cycle latency), order strictly FIFO.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; legal at any count 1..DEPTH-1, and at DEPTH only pop occurs.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-025 fwd_hit SHALL be 1 iff fwd_rs != 31 and some stored entry has rd == fwd_rs; combinational.
REQ-026 On multiple matches fwd_data SHALL be the youngest matching entry; fwd_data SHALL be 0 when !fwd_hit.
REQ-027 Entry popped in the current cycle SHALL still be a forwarding candidate in that cycle; entry being pushed SHALL NOT be.
REQ-028 out_* SHALL remain stable while out_valid && !out_ready.

Reset
REQ-029 rst SHALL immediately clear pointers and count; in_ready=1, out_valid=0, out_*=0, fwd_hit=0.
REQ-030 rst asserted mid-operation SHALL discard all entries, including any handshake in that cycle.
REQ-031 Storage array need not be reset; no output SHALL expose stale data after reset.

Structure
REQ-032 Shared package SHALL hold WIDTH/RA_W defaults, XZR_ADDR = 31, and packed struct result_entry_t {data, cout, rd}.
REQ-033 Block SHALL be single module; storage as array of result_entry_t, no sub-module.

Verification
REQ-034 Push 0x1111 rd=3, 0x2222 rd=4, out_ready=1 -> out shows 0x1111/rd3 then 0x2222/rd4, one cycle after each push.
REQ-035 out_ready=0, push 5 entries (DEPTH=4) -> in_ready=0 after 4th, count=4, 5th held; out_ready=1 one cycle -> 5th accepted next cycle.
REQ-036 Push 0xAAAA rd=31 -> in_ready handshake completes, count stays 0, out_valid=0.
REQ-037 Push 0x5 rd=7 then 0x9 rd=7, fwd_rs=7 -> fwd_hit=1, fwd_data=0x9; fwd_rs=31 -> fwd_hit=0.
REQ-038 count=2, simultaneous push+pop for 8 cycles -> count stays 2, pointers wrap, order preserved.
REQ-039 count=3, assert rst between edges -> out_valid=0, count=0 immediately; post-reset push 0x7 rd=1 appears as first output.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// Shared types and constants for the ALU result buffer.
// result_entry_t is one buffered ALU result as it waits for writeback.
package alu_result_buffer_pkg;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_RA_W  = 5;
    localparam int unsigned XZR_ADDR  = 31;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 cout;
        logic [DEF_RA_W-1:0]  rd;
    } result_entry_t;

endpackage

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results awaiting writeback, with youngest-match operand forwarding.
// Writes to XZR complete the handshake but are dropped instead of stored.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RA_W  = DEF_RA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_cout,
    input  logic [RA_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_cout,
    output logic [RA_W-1:0]            out_rd,
    input  logic [RA_W-1:0]            fwd_rs,
    output logic                       fwd_hit,
    output logic [WIDTH-1:0]           fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    result_entry_t   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;
    result_entry_t   head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && (in_rd != RA_W'(XZR_ADDR));
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign head      = mem[rd_ptr_q];

    // Head fields are forced to zero when empty so stale storage never leaks out.
    assign out_data  = out_valid ? WIDTH'(head.data) : '0;
    assign out_cout  = out_valid ? head.cout         : 1'b0;
    assign out_rd    = out_valid ? RA_W'(head.rd)    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked solely by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{data: DEF_WIDTH'(in_data),
                               cout: in_cout,
                               rd:   DEF_RA_W'(in_rd)};
        end
    end

    // Walk entries oldest to youngest so the last match wins; the entry being
    // pushed this cycle is not yet in storage and so never matches.
    always_comb begin
        logic [AW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if ((CW'(k) < count_q) && (RA_W'(mem[idx].rd) == fwd_rs) &&
                (fwd_rs != RA_W'(XZR_ADDR))) begin
                fwd_hit  = 1'b1;
                fwd_data = WIDTH'(mem[idx].data);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_alu_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned RA_W  = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_cout;
    logic [RA_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cout;
    logic [RA_W-1:0]  out_rd;
    logic [RA_W-1:0]  fwd_rs;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [2:0]       count;

    int tests_run;
    int tests_failed;

    alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cout   (in_cout),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_rd    (out_rd),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_d [4];
        logic [4:0]  exp_r [4];
        logic [63:0] q_d [$];

        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cout   = 1'b0;
        in_rd     = '0;
        out_ready = 1'b0;
        fwd_rs    = '0;

        // Reset state
        #2;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_fwd_hit",   64'(fwd_hit),   64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Two pushes, streaming out with one-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1111;
        in_rd     = 5'd3;
        in_cout   = 1'b1;
        tick();
        in_data = 64'h2222;
        in_rd   = 5'd4;
        in_cout = 1'b0;
        #1;
        check("p1_out_valid", 64'(out_valid), 64'd1);
        check("p1_out_data",  out_data,       64'h1111);
        check("p1_out_rd",    64'(out_rd),    64'd3);
        check("p1_out_cout",  64'(out_cout),  64'd1);
        check("p1_count",     64'(count),     64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("p2_out_data", out_data,    64'h2222);
        check("p2_out_rd",   64'(out_rd), 64'd4);
        check("p2_count",    64'(count),  64'd1);
        tick();
        check("p2_empty_valid", 64'(out_valid), 64'd0);
        check("p2_empty_data",  out_data,       64'd0);

        // XZR destination: handshake completes, nothing stored
        in_valid = 1'b1;
        in_data  = 64'hAAAA;
        in_rd    = 5'd31;
        #1;
        check("xzr_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("xzr_count",     64'(count),     64'd0);
        check("xzr_out_valid", 64'(out_valid), 64'd0);

        // Fill to DEPTH with writeback stalled, fifth entry held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'h10 + i);
            in_rd    = 5'(i + 1);
            tick();
        end
        in_data = 64'h55;
        in_rd   = 5'd9;
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count",    64'(count),    64'd4);
        tick();
        check("held_count",    64'(count), 64'd4);
        check("held_out_data", out_data,   64'h10);
        out_ready = 1'b1;
        #1;
        check("no_bypass_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        check("after_pop_count",    64'(count),    64'd3);
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("fifth_acc_count", 64'(count), 64'd4);
        exp_d = '{64'h11, 64'h12, 64'h13, 64'h55};
        exp_r = '{5'd2, 5'd3, 5'd4, 5'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_data", i), out_data,    exp_d[i]);
            check($sformatf("drain%0d_rd", i),   64'(out_rd), 64'(exp_r[i]));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Forwarding: youngest match, XZR never hits, pushing entry not visible
        in_valid = 1'b1;
        in_data  = 64'h5;
        in_rd    = 5'd7;
        tick();
        in_data = 64'h9;
        tick();
        in_data = 64'h77;
        in_rd   = 5'd12;
        fwd_rs  = 5'd12;
        #1;
        check("fwd_pushing_hit", 64'(fwd_hit), 64'd0);
        fwd_rs = 5'd7;
        #1;
        check("fwd7_hit",  64'(fwd_hit), 64'd1);
        check("fwd7_data", fwd_data,     64'h9);
        tick();
        in_valid = 1'b0;
        fwd_rs   = 5'd31;
        #1;
        check("fwd31_hit",  64'(fwd_hit), 64'd0);
        check("fwd31_data", fwd_data,     64'd0);
        fwd_rs = 5'd12;
        #1;
        check("fwd12_hit",  64'(fwd_hit), 64'd1);
        check("fwd12_data", fwd_data,     64'h77);
        out_ready = 1'b1;
        tick();
        tick();
        check("fwd_popping_hit",  64'(fwd_hit), 64'd1);
        check("fwd_popping_data", fwd_data,     64'h77);
        tick();
        out_ready = 1'b0;
        check("fwd_gone_hit", 64'(fwd_hit), 64'd0);
        check("fwd_gone_cnt", 64'(count),   64'd0);

        // Steady push+pop at count 2 across pointer wraps
        q_d.delete();
        in_valid = 1'b1;
        in_data  = 64'hA1;
        in_rd    = 5'd1;
        tick();
        q_d.push_back(64'hA1);
        in_data = 64'hB2;
        in_rd   = 5'd2;
        tick();
        q_d.push_back(64'hB2);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 64'(32'h100 + k);
            in_rd   = 5'(10 + k);
            #1;
            check($sformatf("ss%0d_count", k), 64'(count), 64'd2);
            check($sformatf("ss%0d_data", k),  out_data,   q_d[0]);
            tick();
            void'(q_d.pop_front());
            q_d.push_back(64'(32'h100 + k));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ss_drain%0d", k), out_data, q_d[0]);
            tick();
            void'(q_d.pop_front());
        end
        out_ready = 1'b0;
        check("ss_empty", 64'(count), 64'd0);

        // Reset mid-operation, including a handshake during reset
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'h31 + i);
            in_rd    = 5'(20 + i);
            tick();
        end
        in_valid = 1'b0;
        fwd_rs   = 5'd21;
        #1;
        check("pre_rst_count", 64'(count),   64'd3);
        check("pre_rst_hit",   64'(fwd_hit), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hEE;
        in_rd    = 5'd5;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count",     64'(count),     64'd0);
        check("mid_rst_out_data",  out_data,       64'd0);
        check("mid_rst_fwd_hit",   64'(fwd_hit),   64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("post_rst_count", 64'(count), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'h7;
        in_rd    = 5'd1;
        tick();
        in_valid = 1'b0;
        #1;
        check("post_rst_data",  out_data,    64'h7);
        check("post_rst_rd",    64'(out_rd), 64'd1);
        check("post_rst_count", 64'(count),  64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
